status_flag_unit: RTL

STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

---
 rtl/status_pkg.sv | 19 +
 rtl/flag_compute.sv | 29 ++
 rtl/status_flag_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/status_pkg.sv
// rtl/status_pkg.sv - shared flag indices, op_class encodings and flags type
package status_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    OP_ARITH = 2'b00,
    OP_LOGIC = 2'b01,
    OP_MUL   = 2'b10,
    OP_RSVD  = 2'b11
  } op_class_e;

  // Packed {z,c,n,v}; this order is what the condition checker decodes.
  typedef logic [3:0] flags_t;

endpackage

// File: rtl/flag_compute.sv
// rtl/flag_compute.sv - combinational next-flag computation from ALU/shifter outputs
module flag_compute
  import status_pkg::*;
(
  input  logic [1:0]  op_class_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_c_i,
  input  logic        alu_v_i,
  input  logic        shift_c_i,
  input  flags_t      base_i,
  output flags_t      flags_o
);

  always_comb begin
    flags_o         = base_i;
    flags_o[FLAG_Z] = (alu_result_i == 32'd0);
    flags_o[FLAG_N] = alu_result_i[31];
    case (op_class_e'(op_class_i))
      OP_ARITH: begin
        flags_o[FLAG_C] = alu_c_i;
        flags_o[FLAG_V] = alu_v_i;
      end
      OP_LOGIC: flags_o[FLAG_C] = shift_c_i;
      // Multiply (and the never-accepted reserved class) keep c/v from base.
      default: ;
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// rtl/status_flag_unit.sv - pending/committed status flags; STATUS_FWD_EN enables pending-flag bypass on sr_fwd
module status_flag_unit
  import status_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  input  logic        s_bit,
  input  logic [1:0]  op_class,
  input  logic [31:0] alu_result,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        shift_c,
  input  logic        stall,
  input  logic        flush,
  output logic [3:0]  sr,
  output logic [3:0]  sr_fwd,
  output logic        upd_pending,
  output logic [15:0] commit_cnt
);

  flags_t      sr_q, sr_d;
  flags_t      pend_q, pend_d;
  logic        pending_q, pending_d;
  logic [15:0] cnt_q, cnt_d;

  flags_t      base;
  flags_t      new_flags;
  logic        accept;
  logic        commit;

  assign accept = upd_valid & s_bit & ~stall & ~flush & (op_class != OP_RSVD);
  assign commit = pending_q & ~stall & ~flush;
  // Back-to-back updates must build on the still-uncommitted flags.
  assign base   = pending_q ? pend_q : sr_q;

  flag_compute u_flag_compute (
    .op_class_i   (op_class),
    .alu_result_i (alu_result),
    .alu_c_i      (alu_c),
    .alu_v_i      (alu_v),
    .shift_c_i    (shift_c),
    .base_i       (base),
    .flags_o      (new_flags)
  );

  always_comb begin
    sr_d      = sr_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (flush) begin
      pend_d    = '0;
      pending_d = 1'b0;
    end else if (!stall) begin
      if (commit) begin
        sr_d      = pend_q;
        cnt_d     = cnt_q + 16'd1;
        pending_d = 1'b0;
      end
      if (accept) begin
        pend_d    = new_flags;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q      <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sr_q      <= sr_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sr          = sr_q;
  assign upd_pending = pending_q;
  assign commit_cnt  = cnt_q;

`ifdef STATUS_FWD_EN
  assign sr_fwd = !rst_n ? 4'b0000 : (pending_q ? pend_q : sr_q);
`else
  assign sr_fwd = !rst_n ? 4'b0000 : sr_q;
`endif

endmodule
